loader_sb_sequencer: RTL and testbench

LOADER_SB_SEQUENCER -- requirements
Module: loader_sb_sequencer

---
 rtl/loader_sb_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_loader_sb_sequencer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/loader_sb_sequencer.sv
// ---------------------------------------------------------------------------
// loader_sb_sequencer
//   Walks the strobe-group loader address space element by element
//   (UMSB, DMSBL1, DMSBL2) and, for every word, handshakes one data word
//   from the source and issues one SELECT strobe with ADDRESS held stable
//   one cycle before and one cycle after the strobe.
//
// Ports
//   CLK         in   single clock, rising edge
//   RESET       in   asynchronous active-low reset
//   START       in   load-sequence request, honoured only in IDLE
//   ABORT       in   synchronous cancel, highest priority
//   DATA_VALID  in   source has the next word available
//   DATA_READY  out  sequencer accepts a word this cycle (WAIT_DATA)
//   SELECT      out  loader select strobe (STROBE)
//   ADDRESS     out  {element, offset}
//   BUSY        out  high in every state except IDLE
//   DONE        out  one-cycle completion pulse (FINISH)
// ---------------------------------------------------------------------------
module loader_sb_sequencer #(
    parameter int ADDRESS_SIZE = 9,
    parameter int NB_ELEMENTS  = 3,
    parameter int WORDS_UMSB   = 4,
    parameter int WORDS_DMSBL1 = 16,
    parameter int WORDS_DMSBL2 = 30
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    START,
    input  logic                    ABORT,
    input  logic                    DATA_VALID,
    output logic                    DATA_READY,
    output logic                    SELECT,
    output logic [ADDRESS_SIZE-1:0] ADDRESS,
    output logic                    BUSY,
    output logic                    DONE
);

    localparam int EB = $clog2(NB_ELEMENTS);
    localparam int OB = ADDRESS_SIZE - EB;
    localparam int CW = OB + 1;   // word counts go up to 2^OB inclusive

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_DATA = 3'd1,
        S_STROBE    = 3'd2,
        S_HOLD      = 3'd3,
        S_FINISH    = 3'd4
    } state_e;

    // Word count of one element; anything beyond the three groups is empty.
    function automatic logic [CW-1:0] words_of(input int e);
        logic [CW-1:0] w;
        case (e)
            32'sd0:  w = CW'(WORDS_UMSB);
            32'sd1:  w = CW'(WORDS_DMSBL1);
            32'sd2:  w = CW'(WORDS_DMSBL2);
            default: w = '0;
        endcase
        return w;
    endfunction

    // Lowest element index >= from with a nonzero word count.
    // Result is {found, index}; scanning downwards lets the lowest hit win.
    function automatic logic [EB:0] next_elem(input int from);
        logic [EB:0] r;
        r = '0;
        for (int i = NB_ELEMENTS - 1; i >= 0; i--) begin
            if ((i >= from) && (words_of(i) != '0)) begin
                r = {1'b1, EB'(i)};
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    state_e         state_q, state_d;
    logic [EB-1:0]  elem_q,  elem_d;
    logic [OB-1:0]  off_q,   off_d;
    logic           rdy_q,   rdy_d;
    logic           sel_q,   sel_d;
    logic           busy_q,  busy_d;
    logic           done_q,  done_d;
    logic [EB:0]    nxt_s;

    // Next-state, address walk and next-output decode.
    always_comb begin
        state_d = state_q;
        elem_d  = elem_q;
        off_d   = off_q;
        nxt_s   = '0;
        case (state_q)
            S_IDLE: begin
                if (START) begin
                    nxt_s = next_elem(32'sd0);
                    if (nxt_s[EB]) begin
                        state_d = S_WAIT_DATA;
                        elem_d  = nxt_s[EB-1:0];
                        off_d   = '0;
                    end else begin
                        state_d = S_FINISH;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT_DATA: begin
                if (DATA_VALID) begin
                    state_d = S_STROBE;
                end else begin
                    state_d = S_WAIT_DATA;
                end
            end
            S_STROBE: begin
                state_d = S_HOLD;
            end
            S_HOLD: begin
                if (({1'b0, off_q} + CW'(32'd1)) < words_of(int'(elem_q))) begin
                    state_d = S_WAIT_DATA;
                    off_d   = off_q + OB'(32'd1);
                end else begin
                    nxt_s = next_elem(int'(elem_q) + 32'sd1);
                    if (nxt_s[EB]) begin
                        state_d = S_WAIT_DATA;
                        elem_d  = nxt_s[EB-1:0];
                        off_d   = '0;
                    end else begin
                        state_d = S_FINISH;
                        elem_d  = '0;
                        off_d   = '0;
                    end
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                elem_d  = '0;
                off_d   = '0;
            end
        endcase

        // Cancel overrides every transition, including START in IDLE.
        if (ABORT) begin
            state_d = S_IDLE;
            elem_d  = '0;
            off_d   = '0;
        end else begin
            state_d = state_d;
        end

        rdy_d  = (state_d == S_WAIT_DATA);
        sel_d  = (state_d == S_STROBE);
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_FINISH);
    end

    // State, address and output registers with asynchronous clear.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= S_IDLE;
            elem_q  <= '0;
            off_q   <= '0;
            rdy_q   <= 1'b0;
            sel_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            elem_q  <= elem_d;
            off_q   <= off_d;
            rdy_q   <= rdy_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign DATA_READY = rdy_q;
    assign SELECT     = sel_q;
    assign ADDRESS    = {elem_q, off_q};
    assign BUSY       = busy_q;
    assign DONE       = done_q;

endmodule

// File: tb/tb_loader_sb_sequencer.sv
// ---------------------------------------------------------------------------
// tb_loader_sb_sequencer
//   Three sequencers share one stimulus: default word counts, DMSBL1 empty,
//   and all groups empty. A cycle model per instance walks a flat list of
//   expected addresses built from the word counts and is compared against
//   the outputs after every clock edge; directed scenarios add literal
//   expectations for timing and address boundaries.
// ---------------------------------------------------------------------------
module tb_loader_sb_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic dv = 1'b0;
    logic [2:0] rdy, sel, busy, done;
    logic [8:0] addr [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    loader_sb_sequencer #(.WORDS_UMSB(4), .WORDS_DMSBL1(16), .WORDS_DMSBL2(30)) dut_a (
        .CLK(clk), .RESET(rst_n), .START(start), .ABORT(abort), .DATA_VALID(dv),
        .DATA_READY(rdy[0]), .SELECT(sel[0]), .ADDRESS(addr[0]), .BUSY(busy[0]), .DONE(done[0]));
    loader_sb_sequencer #(.WORDS_UMSB(4), .WORDS_DMSBL1(0), .WORDS_DMSBL2(30)) dut_b (
        .CLK(clk), .RESET(rst_n), .START(start), .ABORT(abort), .DATA_VALID(dv),
        .DATA_READY(rdy[1]), .SELECT(sel[1]), .ADDRESS(addr[1]), .BUSY(busy[1]), .DONE(done[1]));
    loader_sb_sequencer #(.WORDS_UMSB(0), .WORDS_DMSBL1(0), .WORDS_DMSBL2(0)) dut_c (
        .CLK(clk), .RESET(rst_n), .START(start), .ABORT(abort), .DATA_VALID(dv),
        .DATA_READY(rdy[2]), .SELECT(sel[2]), .ADDRESS(addr[2]), .BUSY(busy[2]), .DONE(done[2]));

    // ---------------- behavioural model ----------------
    localparam int M_IDLE = 0, M_WAIT = 1, M_STB = 2, M_HOLD = 3, M_FIN = 4;
    int         cfg [3][3] = '{'{4, 16, 30}, '{4, 0, 30}, '{0, 0, 0}};
    logic [8:0] alist [3][64];
    int         mlen [3];
    int         mst [3];
    int         midx [3];
    int         edge_n = 0;
    int         start_edge [3];
    int         done_cyc [3];
    bit         done_seen [3];
    logic [8:0] log_a [$];
    logic [8:0] log_b [$];

    task automatic chk(input string nm, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp_v, $time);
        end
    endtask

    task automatic model_step(input int d);
        if (!rst_n) begin
            mst[d] = M_IDLE;
        end else if (abort) begin
            mst[d] = M_IDLE;
        end else begin
            case (mst[d])
                M_IDLE: if (start) begin
                    start_edge[d] = edge_n;
                    midx[d] = 0;
                    mst[d] = (mlen[d] > 0) ? M_WAIT : M_FIN;
                end
                M_WAIT: if (dv) mst[d] = M_STB;
                M_STB:  mst[d] = M_HOLD;
                M_HOLD: begin
                    if (midx[d] + 1 < mlen[d]) begin
                        midx[d]++;
                        mst[d] = M_WAIT;
                    end else begin
                        mst[d] = M_FIN;
                    end
                end
                M_FIN:   mst[d] = M_IDLE;
                default: mst[d] = M_IDLE;
            endcase
        end
    endtask

    task automatic compare(input int d);
        string p;
        p = $sformatf("dut%0d", d);
        chk({p, "_busy"}, int'(busy[d]), int'(mst[d] != M_IDLE));
        chk({p, "_ready"}, int'(rdy[d]), int'(mst[d] == M_WAIT));
        chk({p, "_select"}, int'(sel[d]), int'(mst[d] == M_STB));
        chk({p, "_done"}, int'(done[d]), int'(mst[d] == M_FIN));
        if (mst[d] == M_WAIT || mst[d] == M_STB || mst[d] == M_HOLD)
            chk({p, "_address"}, int'(addr[d]), int'(alist[d][midx[d]]));
        if (done[d]) begin
            done_seen[d] = 1'b1;
            done_cyc[d] = edge_n - start_edge[d] + 1;
        end
    endtask

    // Model advance on each edge, then output comparison just after it.
    always @(posedge clk) begin
        edge_n++;
        for (int d = 0; d < 3; d++) model_step(d);
        #1;
        for (int d = 0; d < 3; d++) compare(d);
        if (sel[0]) log_a.push_back(addr[0]);
        if (sel[1]) begin
            log_b.push_back(addr[1]);
            chk("dut1_no_dmsbl1_addr", int'(addr[1][8:7] == 2'd1), 0);
        end
    end

    // ---------------- stimulus ----------------
    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic do_abort();
        @(negedge clk); abort = 1'b1;
        @(negedge clk); abort = 1'b0;
    endtask

    initial begin
        int n;
        logic [8:0] a_prev;
        for (int d = 0; d < 3; d++) begin
            mlen[d] = 0; mst[d] = M_IDLE; midx[d] = 0;
            for (int e = 0; e < 3; e++)
                for (int o = 0; o < cfg[d][e]; o++) begin
                    alist[d][mlen[d]] = 9'(e * 128 + o);
                    mlen[d]++;
                end
        end

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_busy", int'(busy), 0);
        chk("reset_select", int'(sel), 0);
        chk("reset_ready", int'(rdy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_address", int'(addr[0]), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Full sequence with DATA_VALID held high
        dv = 1'b1;
        log_a.delete(); log_b.delete();
        for (int d = 0; d < 3; d++) done_seen[d] = 1'b0;
        pulse_start();
        n = 0;
        while (!(done_seen[0] && done_seen[1] && done_seen[2]) && n < 400) begin
            @(negedge clk); n++;
        end
        chk("full_seq_timeout", n < 400 ? 1 : 0, 1);
        chk("done_cycles_default", done_cyc[0], 151);
        chk("done_cycles_dmsbl1_empty", done_cyc[1], 103);
        chk("done_cycles_all_empty", done_cyc[2], 1);
        chk("select_count_default", log_a.size(), 50);
        chk("select_count_dmsbl1_empty", log_b.size(), 34);
        if (log_a.size() == 50) begin
            chk("addr_w0", int'(log_a[0]), 'h000);
            chk("addr_w3", int'(log_a[3]), 'h003);
            chk("addr_w4", int'(log_a[4]), 'h080);
            chk("addr_w19", int'(log_a[19]), 'h08F);
            chk("addr_w20", int'(log_a[20]), 'h100);
            chk("addr_w49", int'(log_a[49]), 'h11D);
        end
        if (log_b.size() == 34) begin
            chk("skip_w3", int'(log_b[3]), 'h003);
            chk("skip_w4", int'(log_b[4]), 'h100);
        end
        repeat (3) @(negedge clk);

        // Stall in WAIT_DATA for 10 cycles
        dv = 1'b0;
        pulse_start();
        for (int i = 0; i < 10; i++) begin
            chk("stall_ready", int'(rdy[0]), 1);
            chk("stall_select", int'(sel[0]), 0);
            chk("stall_address", int'(addr[0]), 'h000);
            @(negedge clk);
        end
        dv = 1'b1;
        @(negedge clk);
        chk("resume_select", int'(sel[0]), 1);
        chk("resume_address", int'(addr[0]), 'h000);
        do_abort();
        repeat (2) @(negedge clk);

        // Abort during the strobe of word 0x085
        pulse_start();
        n = 0;
        while (!(sel[0] && addr[0] == 9'h085) && n < 200) begin
            @(negedge clk); n++;
        end
        chk("abort_target_timeout", n < 200 ? 1 : 0, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", int'(busy[0]), 0);
        chk("abort_done", int'(done[0]), 0);
        chk("abort_select", int'(sel[0]), 0);
        chk("abort_ready", int'(rdy[0]), 0);
        chk("abort_address", int'(addr[0]), 'h000);
        @(negedge clk);
        chk("abort_no_late_done", int'(done[0]), 0);
        pulse_start();
        chk("restart_address", int'(addr[0]), 'h000);
        chk("restart_ready", int'(rdy[0]), 1);
        @(negedge clk);
        chk("restart_select_addr", int'(addr[0]), 'h000);

        // START pulses while busy, then asynchronous reset in HOLD
        n = 0;
        while (n < 20) begin
            @(negedge clk); n++;
            start = n[0];
        end
        start = 1'b0;
        n = 0;
        while (!sel[0] && n < 10) begin
            @(negedge clk); n++;
        end
        @(negedge clk);
        chk("hold_busy", int'(busy[0]), 1);
        chk("hold_select", int'(sel[0]), 0);
        a_prev = addr[0];
        #2 rst_n = 1'b0;
        #1;
        chk("async_busy", int'(busy), 0);
        chk("async_select", int'(sel), 0);
        chk("async_ready", int'(rdy), 0);
        chk("async_done", int'(done), 0);
        chk("async_address", int'(addr[0]), 0);
        chk("async_address_b", int'(addr[1]), 0);
        @(negedge clk);
        rst_n = 1'b1;
        pulse_start();
        chk("post_reset_address", int'(addr[0]), 'h000);
        chk("post_reset_changed", int'(a_prev != 9'h000), 1);

        // Randomized traffic checked every cycle by the model
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            start = ($urandom_range(0, 3) == 0);
            dv    = ($urandom_range(0, 2) != 0);
            abort = ($urandom_range(0, 59) == 0);
        end
        start = 1'b0; abort = 1'b0;
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
